// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: operand/result handshake bundle between the execute stage
// (master) and the iterative multiply/divide unit (slave).
interface muldiv_seq_if #(
    parameter int W = 32
);
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic         signed_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         div_zero;

    modport master (
        output flush, in_valid, op, signed_op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, div_zero
    );

    modport slave (
        input  flush, in_valid, op, signed_op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, div_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiplier / restoring divider, one result
// bit per clock, W cycles per op, valid/ready on both sides.
// Optional feature macro: MULDIV_SIGNED_EN -- when defined, signed_op selects
// two's-complement operands (magnitude on entry, sign fix-up on exit); when
// undefined every op is unsigned and no negation logic is built.
module muldiv_seq #(
    parameter  int W  = 32,
    localparam int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    // hi_q: high product / partial remainder; lo_q: multiplier / dividend-quotient
    logic [W-1:0]   hi_q, lo_q, opnd_q;
    logic           is_div_q, is_mod_q, dz_q;

    logic           accept, in_div, last;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     add_sum, shifted;
    logic [W-1:0]   diff, hi_nx, lo_nx;
    logic           ge;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, res_d, res_hi_d;
    logic [W-1:0]   result_q, result_hi_q;
    logic           div_zero_q;

    // flush wins over a same-cycle accept
    assign accept = bus.in_valid && (state_q == IDLE) && !bus.flush;
    assign in_div = (bus.op == 2'b01) || (bus.op == 2'b10);
    assign last   = (state_q == RUN) && (cnt_q == CW'(1));

`ifdef MULDIV_SIGNED_EN
    logic sa, sb, neg_q_q, neg_r_q;

    assign sa    = bus.signed_op & bus.a[W-1];
    assign sb    = bus.signed_op & bus.b[W-1];
    assign mag_a = sa ? -bus.a : bus.a;
    assign mag_b = sb ? -bus.b : bus.b;

    // Result signs are captured at accept so operands need not be kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (accept) begin
            neg_q_q <= sa ^ sb;
            neg_r_q <= sa;
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = bus.signed_op;
    assign mag_a = bus.a;
    assign mag_b = bus.b;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: IDLE -> RUN on accept, RUN -> DONE on last bit,
    // DONE -> IDLE on out_ready; flush returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // One iteration of the shared datapath: shift-add for MUL, restoring
    // subtract for DIV/MOD. The remainder never exceeds the divisor, so W bits
    // of hi_q suffice; only the shifted trial value needs W+1 bits.
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        shifted = {hi_q, lo_q[W-1]};
        ge      = shifted >= {1'b0, opnd_q};
        diff    = shifted[W-1:0] - opnd_q;
        if (is_div_q) begin
            hi_nx = ge ? diff : shifted[W-1:0];
            lo_nx = {lo_q[W-2:0], ge};
        end else begin
            hi_nx = add_sum[W:1];
            lo_nx = {add_sum[0], lo_q[W-1:1]};
        end
    end

    // Final result from the last iteration, with sign fix-up and the
    // divide-by-zero quotient override (remainder already equals the dividend).
    always_comb begin
        prod = {hi_nx, lo_nx};
        quo  = lo_nx;
        rem  = hi_nx;
`ifdef MULDIV_SIGNED_EN
        if (neg_q_q) begin
            prod = -prod;
            quo  = -quo;
        end
        if (neg_r_q) rem = -rem;
`endif
        if (dz_q) quo = {W{1'b1}};
        if (is_div_q) begin
            res_d    = is_mod_q ? rem : quo;
            res_hi_d = rem;
        end else begin
            res_d    = prod[W-1:0];
            res_hi_d = prod[2*W-1:W];
        end
    end

    // Operand capture at accept, then one bit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            is_mod_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q    <= CW'(W);
            hi_q     <= '0;
            lo_q     <= in_div ? mag_a : mag_b;
            opnd_q   <= in_div ? mag_b : mag_a;
            is_div_q <= in_div;
            is_mod_q <= (bus.op == 2'b10);
            dz_q     <= in_div && (bus.b == '0);
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q - CW'(1);
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
        end
    end

    // Output registers load only on the final iteration; held through DONE
    // and deliberately left untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            div_zero_q  <= 1'b0;
        end else if (last && !bus.flush) begin
            result_q    <= res_d;
            result_hi_q <= res_hi_d;
            div_zero_q  <= dz_q;
        end
    end

    // Handshake decoded from state only; in_ready is also held low in reset.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq (W=32) against
// a plain-arithmetic reference model.
module tb_muldiv_seq;
    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    muldiv_seq_if #(.W(W)) m ();

    muldiv_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: plain integer arithmetic on the operands as the spec defines.
    function automatic void model(input logic [1:0] o, input logic s, input logic [31:0] x, y,
                                  output logic [31:0] r, rh, output logic dz);
        logic        sg;
        logic [31:0] q, rm;
        logic [63:0] p;
        longint      lx, ly;
        sg = s & SIGNED_EN;
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        dz = 1'b0;
        if (o == 2'd1 || o == 2'd2) begin
            if (y == 32'd0) begin
                q = '1; rm = x; dz = 1'b1;
            end else if (sg) begin
                q  = 32'(lx / ly);
                rm = 32'(lx % ly);
            end else begin
                q  = x / y;
                rm = x % y;
            end
            r  = (o == 2'd2) ? rm : q;
            rh = rm;
        end else begin
            if (sg) p = 64'(lx * ly);
            else    p = {32'd0, x} * {32'd0, y};
            r  = p[31:0];
            rh = p[63:32];
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present one op and wait for the accepting edge (unit assumed idle-bound).
    task automatic start(input logic [1:0] o, input logic s, input logic [31:0] x, y);
        int n;
        n = 0;
        while (m.in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        m.in_valid = 1'b1; m.op = o; m.signed_op = s; m.a = x; m.b = y;
        @(posedge clk); #1;
        acc_cyc = cyc;
        // scramble operands after accept: they must be ignored from here on
        m.in_valid = 1'b0; m.op = 2'($urandom); m.a = $urandom; m.b = $urandom;
        m.signed_op = 1'($urandom);
    endtask

    task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] x, y, output int lat);
        start(o, s, x, y);
        lat = 0;
        while (m.out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic take();
        m.out_ready = 1'b1;
        @(posedge clk); #1;
        m.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({m.in_ready, m.out_valid, m.result, m.result_hi, m.div_zero} !== '0) begin
            bad++; $display("FAIL reset_outputs got rdy=%b vld=%b r=%h rh=%h dz=%b want all 0",
                            m.in_ready, m.out_valid, m.result, m.result_hi, m.div_zero);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (m.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", m.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_vector(input string nm, input logic [1:0] o, input logic s,
                               input logic [31:0] x, y, input logic [64:0] want, input bit rdy);
        int lat;
        m.out_ready = rdy;
        issue(o, s, x, y, lat);
        total++;
        if (lat !== W) begin bad++; $display("FAIL %s_latency got %0d want %0d", nm, lat, W); end
        total++;
        if ({m.result, m.result_hi, m.div_zero} !== want) begin
            bad++; $display("FAIL %s got r=%h rh=%h dz=%b want %h", nm, m.result, m.result_hi, m.div_zero, want);
        end
        if (rdy) begin @(posedge clk); #1; m.out_ready = 1'b0; end
        else take();
    endtask

    task automatic test_directed();
        logic [31:0] r, rh; logic dz;
        test_vector("mul_7x6", 2'd0, 1'b0, 32'd7, 32'd6, {32'd42, 32'd0, 1'b0}, 1'b1);
        test_vector("div_100_7", 2'd1, 1'b0, 32'd100, 32'd7, {32'd14, 32'd2, 1'b0}, 1'b0);
        test_vector("mod_100_7", 2'd2, 1'b0, 32'd100, 32'd7, {32'd2, 32'd2, 1'b0}, 1'b0);
        test_vector("div_by_zero", 2'd1, 1'b0, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5, 1'b1}, 1'b0);
        test_vector("op3_is_mul", 2'd3, 1'b0, 32'h0001_0000, 32'h0003_0000, {32'd0, 32'd3, 1'b0}, 1'b1);
`ifdef MULDIV_SIGNED_EN
        test_vector("sdiv_m7_2", 2'd1, 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}, 1'b0);
        test_vector("smul_m3_5", 2'd0, 1'b1, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0}, 1'b0);
        test_vector("sdiv_min_m1", 2'd1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0, 1'b0}, 1'b0);
        test_vector("smod_zero", 2'd2, 1'b1, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFF9, 1'b1}, 1'b0);
`else
        model(2'd1, 1'b1, 32'hFFFF_FFF9, 32'd2, r, rh, dz);
        test_vector("signed_ignored_div", 2'd1, 1'b1, 32'hFFFF_FFF9, 32'd2, {r, rh, dz}, 1'b0);
        model(2'd0, 1'b1, 32'hFFFF_FFFD, 32'd5, r, rh, dz);
        test_vector("signed_ignored_mul", 2'd0, 1'b1, 32'hFFFF_FFFD, 32'd5, {r, rh, dz}, 1'b0);
`endif
    endtask

    task automatic test_random();
        logic [1:0] o; logic s; logic [31:0] x, y, r, rh; logic dz;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3)); s = 1'($urandom); x = pick(); y = pick();
            model(o, s, x, y, r, rh, dz);
            test_vector("random", o, s, x, y, {r, rh, dz}, 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        int first, lat;
        m.out_ready = 1'b1;
        issue(2'd0, 1'b0, 32'd9, 32'd9, lat);
        first = acc_cyc;
        issue(2'd1, 1'b0, 32'd81, 32'd9, lat);
        total++;
        if (acc_cyc - first !== W + 2) begin
            bad++; $display("FAIL issue_interval got %0d want %0d", acc_cyc - first, W + 2);
        end
        total++;
        if ({m.result, m.result_hi} !== {32'd9, 32'd0}) begin
            bad++; $display("FAIL b2b_result got %h/%h want 9/0", m.result, m.result_hi);
        end
        @(posedge clk); #1;
        m.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] r, rh, x, y; logic dz; logic [65:0] snap; int lat;
        x = $urandom; y = $urandom_range(1, 1000);
        m.out_ready = 1'b0;
        issue(2'd1, 1'b0, x, y, lat);
        model(2'd1, 1'b0, x, y, r, rh, dz);
        total++;
        if ({m.result, m.result_hi, m.div_zero} !== {r, rh, dz}) begin
            bad++; $display("FAIL bp_result got %h/%h want %h/%h", m.result, m.result_hi, r, rh);
        end
        snap = {m.out_valid, m.in_ready, m.result, m.result_hi};
        for (int i = 0; i < 10; i++) begin
            m.a = $urandom; m.b = $urandom; m.op = 2'($urandom);
            @(posedge clk); #1;
            total++;
            if ({m.out_valid, m.in_ready, m.result, m.result_hi} !== {1'b1, 1'b0, r, rh}) begin
                bad++; $display("FAIL bp_hold cycle %0d got %h want %h", i,
                                {m.out_valid, m.in_ready, m.result, m.result_hi}, snap);
            end
        end
        // release with a new op already pending: it must not be taken this edge
        m.out_ready = 1'b1; m.in_valid = 1'b1; m.op = 2'd0; m.signed_op = 1'b0;
        m.a = 32'd11; m.b = 32'd13;
        @(posedge clk); #1;
        m.out_ready = 1'b0;
        total++;
        if ({m.in_ready, m.out_valid} !== 2'b10) begin
            bad++; $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", m.in_ready, m.out_valid);
        end
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        lat = 0;
        while (m.out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        total++;
        if ({lat, m.result} !== {W, 32'd143}) begin
            bad++; $display("FAIL bp_next_op got lat=%0d r=%0d want lat=%0d r=143", lat, m.result, W);
        end
        take();
    endtask

    task automatic test_flush();
        logic [31:0] prev; int seen;
        prev = m.result;
        start(2'd0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
        m.flush = 1'b1;
        @(posedge clk); #1;
        m.flush = 1'b0;
        total++;
        if ({m.in_ready, m.out_valid, m.result} !== {2'b10, prev}) begin
            bad++; $display("FAIL flush_run got rdy=%b vld=%b r=%h want rdy=1 vld=0 r=%h",
                            m.in_ready, m.out_valid, m.result, prev);
        end
        // same-cycle flush and request: request is dropped
        m.in_valid = 1'b1; m.flush = 1'b1; m.op = 2'd1; m.a = 32'd50; m.b = 32'd5;
        @(posedge clk); #1;
        m.in_valid = 1'b0; m.flush = 1'b0;
        total++;
        if (m.in_ready !== 1'b1) begin bad++; $display("FAIL flush_priority got rdy=%b want 1", m.in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (m.out_valid === 1'b1) seen++; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL flush_no_valid got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        start(2'd1, 1'b0, 32'd1000, 32'd3);
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({m.in_ready, m.out_valid, m.result, m.result_hi, m.div_zero} !== '0) begin
            bad++; $display("FAIL reset_async got rdy=%b vld=%b r=%h rh=%h dz=%b want all 0",
                            m.in_ready, m.out_valid, m.result, m.result_hi, m.div_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (m.out_valid === 1'b1) seen++; end
        total++;
        if ({seen, m.in_ready} !== {32'd0, 1'b1}) begin
            bad++; $display("FAIL reset_no_valid got %0d valid cycles rdy=%b want 0 and 1", seen, m.in_ready);
        end
    endtask

    initial begin
        m.flush = 1'b0; m.in_valid = 1'b0; m.op = 2'd0; m.signed_op = 1'b0;
        m.a = '0; m.b = '0; m.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
